// File: rtl/pe_relay_fifo.sv
// Four-direction relay tile for the PE mesh: one independent valid/ready FIFO
// per direction, with ap_start freezing all traffic without losing words.

module pe_relay_fifo_chan #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ap_start,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  push, pop;

  // Ready is gated by reset_n so it drops immediately on an async reset.
  always_comb begin
    in_ready  = reset_n & ap_start & (level_q < FULL_LEVEL);
    out_valid = ap_start & (level_q != '0);
    out_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign level = level_q;
endmodule

module pe_relay_fifo #(
  parameter int EAST_WIDTH      = 130,
  parameter int WEST_WIDTH      = 260,
  parameter int NORTH_WIDTH     = 260,
  parameter int SOUTH_WIDTH     = 166,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ap_start,
  input  logic [EAST_WIDTH-1:0]      in_from_east,
  input  logic                       in_from_east_valid,
  output logic                       in_from_east_ready,
  output logic [EAST_WIDTH-1:0]      out_to_east,
  output logic                       out_to_east_valid,
  input  logic                       out_to_east_ready,
  output logic [FIFO_DEPTH_LOG2:0]   level_east,
  input  logic [WEST_WIDTH-1:0]      in_from_west,
  input  logic                       in_from_west_valid,
  output logic                       in_from_west_ready,
  output logic [WEST_WIDTH-1:0]      out_to_west,
  output logic                       out_to_west_valid,
  input  logic                       out_to_west_ready,
  output logic [FIFO_DEPTH_LOG2:0]   level_west,
  input  logic [NORTH_WIDTH-1:0]     in_from_north,
  input  logic                       in_from_north_valid,
  output logic                       in_from_north_ready,
  output logic [NORTH_WIDTH-1:0]     out_to_north,
  output logic                       out_to_north_valid,
  input  logic                       out_to_north_ready,
  output logic [FIFO_DEPTH_LOG2:0]   level_north,
  input  logic [SOUTH_WIDTH-1:0]     in_from_south,
  input  logic                       in_from_south_valid,
  output logic                       in_from_south_ready,
  output logic [SOUTH_WIDTH-1:0]     out_to_south,
  output logic                       out_to_south_valid,
  input  logic                       out_to_south_ready,
  output logic [FIFO_DEPTH_LOG2:0]   level_south
);
  pe_relay_fifo_chan #(.WIDTH(EAST_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_east (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_data(in_from_east), .in_valid(in_from_east_valid), .in_ready(in_from_east_ready),
    .out_data(out_to_east), .out_valid(out_to_east_valid), .out_ready(out_to_east_ready),
    .level(level_east)
  );

  pe_relay_fifo_chan #(.WIDTH(WEST_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_west (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_data(in_from_west), .in_valid(in_from_west_valid), .in_ready(in_from_west_ready),
    .out_data(out_to_west), .out_valid(out_to_west_valid), .out_ready(out_to_west_ready),
    .level(level_west)
  );

  pe_relay_fifo_chan #(.WIDTH(NORTH_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_north (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_data(in_from_north), .in_valid(in_from_north_valid), .in_ready(in_from_north_ready),
    .out_data(out_to_north), .out_valid(out_to_north_valid), .out_ready(out_to_north_ready),
    .level(level_north)
  );

  pe_relay_fifo_chan #(.WIDTH(SOUTH_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_south (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_data(in_from_south), .in_valid(in_from_south_valid), .in_ready(in_from_south_ready),
    .out_data(out_to_south), .out_valid(out_to_south_valid), .out_ready(out_to_south_ready),
    .level(level_south)
  );
endmodule

// File: tb/tb_pe_relay_fifo.sv
// Randomized and directed bench for pe_relay_fifo against a queue-based model
// of four independent depth-4 FIFOs.

module tb_pe_relay_fifo;
  localparam int EW = 130, WW = 260, NW = 260, SW = 166;
  localparam int LOG2 = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n, ap_start;
  logic [259:0] in_d [4];
  logic [3:0] in_v, out_r;
  wire  [3:0] in_r, out_v;
  wire  [EW-1:0] out_e;
  wire  [WW-1:0] out_w;
  wire  [NW-1:0] out_n;
  wire  [SW-1:0] out_s;
  wire  [LOG2:0] lvl_e, lvl_w, lvl_n, lvl_s;
  logic [259:0] out_d [4];
  logic [LOG2:0] lvl [4];

  logic [259:0] mdl [4][$];
  int widths [4] = '{EW, WW, NW, SW};
  string nm [4] = '{"east", "west", "north", "south"};
  bit popped [4];
  logic [259:0] pop_word [4];
  int tests = 0, failures = 0;

  always #5 clk = ~clk;

  pe_relay_fifo #(.EAST_WIDTH(EW), .WEST_WIDTH(WW), .NORTH_WIDTH(NW),
                  .SOUTH_WIDTH(SW), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_from_east(in_d[0][EW-1:0]), .in_from_east_valid(in_v[0]), .in_from_east_ready(in_r[0]),
    .out_to_east(out_e), .out_to_east_valid(out_v[0]), .out_to_east_ready(out_r[0]),
    .level_east(lvl_e),
    .in_from_west(in_d[1][WW-1:0]), .in_from_west_valid(in_v[1]), .in_from_west_ready(in_r[1]),
    .out_to_west(out_w), .out_to_west_valid(out_v[1]), .out_to_west_ready(out_r[1]),
    .level_west(lvl_w),
    .in_from_north(in_d[2][NW-1:0]), .in_from_north_valid(in_v[2]), .in_from_north_ready(in_r[2]),
    .out_to_north(out_n), .out_to_north_valid(out_v[2]), .out_to_north_ready(out_r[2]),
    .level_north(lvl_n),
    .in_from_south(in_d[3][SW-1:0]), .in_from_south_valid(in_v[3]), .in_from_south_ready(in_r[3]),
    .out_to_south(out_s), .out_to_south_valid(out_v[3]), .out_to_south_ready(out_r[3]),
    .level_south(lvl_s)
  );

  // Widen every channel's outputs to a common 260-bit view for the checker.
  always_comb begin
    out_d[0] = {{(260-EW){1'b0}}, out_e};
    out_d[1] = out_w;
    out_d[2] = out_n;
    out_d[3] = {{(260-SW){1'b0}}, out_s};
    lvl[0] = lvl_e;
    lvl[1] = lvl_w;
    lvl[2] = lvl_n;
    lvl[3] = lvl_s;
  end

  function automatic logic [259:0] randWord(input int c);
    logic [259:0] r, m;
    r = '0;
    for (int k = 0; k < 9; k++) r = {r[227:0], 32'($urandom())};
    m = '1;
    m = m >> (260 - widths[c]);
    return r & m;
  endfunction

  task automatic checkOutput(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every channel's visible state against the queue model.
  task automatic checkAll();
    for (int c = 0; c < 4; c++) begin
      int sz;
      logic exp_ready, exp_valid;
      logic [259:0] exp_data;
      sz = mdl[c].size();
      exp_ready = reset_n && ap_start && (sz < DEPTH);
      exp_valid = ap_start && (sz > 0);
      exp_data = (sz > 0) ? mdl[c][0] : '0;
      checkOutput($sformatf("%s_level", nm[c]), 260'(lvl[c]), 260'(sz));
      checkOutput($sformatf("%s_in_ready", nm[c]), 260'(in_r[c]), 260'(exp_ready));
      checkOutput($sformatf("%s_out_valid", nm[c]), 260'(out_v[c]), 260'(exp_valid));
      checkOutput($sformatf("%s_out_data", nm[c]), out_d[c], exp_data);
    end
  endtask

  // One clock cycle: entered just after a rising edge with inputs set.
  task automatic applyStimulus();
    bit do_push [4];
    bit do_pop [4];
    #4;
    checkAll();
    for (int c = 0; c < 4; c++) begin
      do_push[c] = in_v[c] && ap_start && (mdl[c].size() < DEPTH);
      do_pop[c] = out_r[c] && ap_start && (mdl[c].size() > 0);
      popped[c] = do_pop[c];
      pop_word[c] = out_d[c];
    end
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      if (do_pop[c]) void'(mdl[c].pop_front());
      if (do_push[c]) mdl[c].push_back(in_d[c]);
    end
    #1;
  endtask

  task automatic idleInputs();
    in_v = '0;
    out_r = '0;
  endtask

  task automatic drainAll();
    idleInputs();
    out_r = '1;
    for (int k = 0; k < 8; k++) applyStimulus();
    out_r = '0;
  endtask

  initial begin
    logic [259:0] recv [$];
    int sent;
    reset_n = 1'b0;
    ap_start = 1'b0;
    idleInputs();
    for (int c = 0; c < 4; c++) in_d[c] = '0;
    #1;
    checkAll();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ap_start = 1'b1;

    // Latency: one word into empty east, visible the cycle after the push.
    in_v[0] = 1'b1;
    in_d[0] = 260'h1;
    applyStimulus();
    in_v[0] = 1'b0;
    checkOutput("lat_east_valid", 260'(out_v[0]), 260'h1);
    checkOutput("lat_east_data", out_d[0], 260'h1);
    checkOutput("lat_east_level", 260'(lvl[0]), 260'h1);
    out_r[0] = 1'b1;
    applyStimulus();
    out_r[0] = 1'b0;
    checkOutput("lat_east_level_after_pop", 260'(lvl[0]), 260'h0);
    checkOutput("lat_east_data_after_pop", out_d[0], 260'h0);

    // Full: push 1..5 to north with no consumer; only four fit.
    for (int i = 1; i <= 5; i++) begin
      in_v[2] = 1'b1;
      in_d[2] = 260'(i);
      applyStimulus();
    end
    in_v[2] = 1'b0;
    checkOutput("full_north_level", 260'(lvl[2]), 260'h4);
    checkOutput("full_north_ready", 260'(in_r[2]), 260'h0);
    out_r[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("full_drain_%0d", i), pop_word[2], 260'(i));
    end
    out_r[2] = 1'b0;

    // Full with simultaneous valid/ready: pop only, then push and pop together.
    for (int i = 0; i < 4; i++) begin
      in_v[2] = 1'b1;
      in_d[2] = randWord(2);
      applyStimulus();
    end
    in_d[2] = 260'h9;
    out_r[2] = 1'b1;
    applyStimulus();
    checkOutput("fullsim_level_pop_only", 260'(lvl[2]), 260'h3);
    checkOutput("fullsim_ready_next", 260'(in_r[2]), 260'h1);
    in_d[2] = 260'hA;
    applyStimulus();
    checkOutput("fullsim_level_both", 260'(lvl[2]), 260'h3);
    drainAll();

    // Freeze: south holds two words while ap_start is low.
    for (int i = 0; i < 2; i++) begin
      in_v[3] = 1'b1;
      in_d[3] = randWord(3);
      applyStimulus();
    end
    ap_start = 1'b0;
    in_d[3] = randWord(3);
    out_r[3] = 1'b1;
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("freeze_south_level", 260'(lvl[3]), 260'h2);
    ap_start = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus();
    drainAll();

    // Reset mid-stream: two words in every channel, then async reset.
    for (int i = 0; i < 2; i++) begin
      in_v = '1;
      for (int c = 0; c < 4; c++) in_d[c] = randWord(c);
      applyStimulus();
    end
    idleInputs();
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) mdl[c].delete();
    #2;
    checkAll();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    in_v[0] = 1'b1;
    in_d[0] = 260'h77;
    applyStimulus();
    in_v[0] = 1'b0;
    checkOutput("reset_first_word", out_d[0], 260'h77);
    drainAll();

    // Wrap: 20 words on west with the consumer toggling 1,0,1,0.
    sent = 0;
    for (int cyc = 0; cyc < 200 && recv.size() < 20; cyc++) begin
      in_v[1] = (sent < 20);
      in_d[1] = 260'(sent + 1);
      out_r[1] = (cyc % 2 == 0);
      if (in_v[1] && in_r[1]) sent++;
      applyStimulus();
      if (popped[1]) recv.push_back(pop_word[1]);
    end
    idleInputs();
    checkOutput("wrap_count", 260'(recv.size()), 260'd20);
    for (int i = 0; i < recv.size(); i++)
      checkOutput($sformatf("wrap_word_%0d", i), recv[i], 260'(i + 1));

    // Random traffic on all four channels with occasional freezes.
    for (int k = 0; k < 400; k++) begin
      ap_start = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 4; c++) begin
        in_v[c] = $urandom_range(0, 1);
        out_r[c] = $urandom_range(0, 1);
        in_d[c] = randWord(c);
      end
      applyStimulus();
    end
    ap_start = 1'b1;
    drainAll();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
